gsim_param_solver: RTL and testbench

//  Parametrised Gauss-Seidel solver. It is the successor to the fixed 16-unknown GSIM block.
//  - Solves A*x = b for the symmetric banded Toeplitz matrix: diagonal 20, off-diagonals -13, 6, -1.
//  - Number of unknowns, data widths and iteration limit are set by parameters.
//  - Optional early exit on convergence. Reports sweep count and a sticky overflow flag.
//  - Sits between the b-vector stream source and the x-result consumer.

---
 rtl/gsim_param_solver.sv | 178 +++++++++++++++++
 tb/tb_gsim_param_solver.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gsim_param_solver.sv
// Parametrised Gauss-Seidel solver for the banded Toeplitz system (20, -13, 6, -1).
// Loads b[], sweeps one unknown per cycle until convergence or MAX_ITER, then streams x[].
module gsim_param_solver #(
   parameter int unsigned N        = 16,
   parameter int unsigned BW       = 16,
   parameter int unsigned XW       = 32,
   parameter int unsigned FRAC     = 16,
   parameter int unsigned MAX_ITER = 64,
   parameter bit          CONV_EN  = 1'b1,
   parameter int unsigned TOL      = 0
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              in_en,
   input  logic [BW-1:0]                     b_in,
   output logic                              in_ready,
   output logic                              out_valid,
   output logic                              out_last,
   output logic [XW-1:0]                     x_out,
   output logic [$clog2(MAX_ITER+1)-1:0]     iter_cnt,
   output logic                              converged,
   output logic                              ovf
);

   localparam int unsigned IdxW  = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned IterW = $clog2(MAX_ITER + 1);
   // Wide enough for both the shifted b term and the weighted neighbour sum.
   localparam int unsigned SumW  = (XW + 8 > BW + FRAC + 1) ? XW + 8 : BW + FRAC + 1;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StLoad  = 2'd1;
   localparam logic [1:0] StSolve = 2'd2;
   localparam logic [1:0] StOut   = 2'd3;

   localparam logic [IdxW-1:0]        LastIdx = IdxW'(N - 1);
   localparam logic [IterW-1:0]       MaxIt   = IterW'(MAX_ITER);
   localparam logic [XW:0]            TolV    = (XW + 1)'(TOL);
   localparam logic signed [SumW-1:0] Div     = SumW'(20);
   localparam logic signed [SumW-1:0] One     = SumW'(1);
   localparam logic signed [SumW-1:0] SatHi   = SumW'({1'b0, {(XW - 1){1'b1}}});
   localparam logic signed [SumW-1:0] SatLo   = ~SatHi;

   logic [1:0]             state_q;
   logic [IdxW-1:0]        idx_q;
   logic [31:0]            idx_w;
   logic signed [XW-1:0]   x_q [N];
   logic signed [BW-1:0]   b_q [N];
   logic [IterW-1:0]       iter_q, iter_nxt;
   logic [XW:0]            maxd_q;
   logic                   conv_q, ovf_q;

   logic signed [XW-1:0]   x_old, x_new;
   logic signed [BW-1:0]   b_cur;
   logic signed [SumW-1:0] n1, n2, n3, bterm, s, q, r;
   logic [XW:0]            dx, absd, sweep_max;
   logic                   sat;

   function automatic logic signed [SumW-1:0] sx(input logic signed [XW-1:0] v);
      return {{(SumW - XW){v[XW-1]}}, v};
   endfunction

   assign idx_w = 32'(idx_q);

   always_comb begin
      x_old = '0;
      b_cur = '0;
      n1    = '0;
      n2    = '0;
      n3    = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (k == idx_w) begin
            x_old = x_q[k];
            b_cur = b_q[k];
         end
         if (k + 1 == idx_w || k == idx_w + 1) n1 = n1 + sx(x_q[k]);
         if (k + 2 == idx_w || k == idx_w + 2) n2 = n2 + sx(x_q[k]);
         if (k + 3 == idx_w || k == idx_w + 3) n3 = n3 + sx(x_q[k]);
      end
      bterm = {{(SumW - BW){b_cur[BW-1]}}, b_cur} <<< FRAC;
      s = bterm + (n1 <<< 3) + (n1 <<< 2) + n1 - (n2 <<< 2) - (n2 <<< 1) + n3;
      // Signed division truncates toward zero; step down once for negative inexact sums.
      q = s / Div;
      r = s % Div;
      if (s[SumW-1] && (r != '0)) q = q - One;
      sat = 1'b0;
      if (q > SatHi) begin
         x_new = {1'b0, {(XW - 1){1'b1}}};
         sat   = 1'b1;
      end else if (q < SatLo) begin
         x_new = {1'b1, {(XW - 1){1'b0}}};
         sat   = 1'b1;
      end else begin
         x_new = q[XW-1:0];
      end
      dx        = {x_new[XW-1], x_new} - {x_old[XW-1], x_old};
      absd      = dx[XW] ? -dx : dx;
      sweep_max = (absd > maxd_q) ? absd : maxd_q;
      iter_nxt  = iter_q + IterW'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         idx_q   <= '0;
         iter_q  <= '0;
         maxd_q  <= '0;
         conv_q  <= 1'b0;
         ovf_q   <= 1'b0;
         for (int unsigned k = 0; k < N; k++) begin
            x_q[k] <= '0;
            b_q[k] <= '0;
         end
      end else begin
         case (state_q)
            StIdle: if (in_en) begin
               b_q[0] <= b_in;
               iter_q <= '0;
               maxd_q <= '0;
               conv_q <= 1'b0;
               ovf_q  <= 1'b0;
               for (int unsigned k = 0; k < N; k++) x_q[k] <= '0;
               if (N == 1) begin
                  state_q <= StSolve;
                  idx_q   <= '0;
               end else begin
                  state_q <= StLoad;
                  idx_q   <= IdxW'(1);
               end
            end
            StLoad: if (in_en) begin
               for (int unsigned k = 0; k < N; k++) if (k == idx_w) b_q[k] <= b_in;
               if (idx_q == LastIdx) begin
                  state_q <= StSolve;
                  idx_q   <= '0;
               end else begin
                  idx_q <= idx_q + IdxW'(1);
               end
            end
            StSolve: begin
               for (int unsigned k = 0; k < N; k++) if (k == idx_w) x_q[k] <= x_new;
               if (sat) ovf_q <= 1'b1;
               if (idx_q == LastIdx) begin
                  iter_q <= iter_nxt;
                  idx_q  <= '0;
                  maxd_q <= '0;
                  if (CONV_EN && (sweep_max <= TolV)) begin
                     conv_q  <= 1'b1;
                     state_q <= StOut;
                  end else if (iter_nxt == MaxIt) begin
                     state_q <= StOut;
                  end
               end else begin
                  idx_q  <= idx_q + IdxW'(1);
                  maxd_q <= sweep_max;
               end
            end
            StOut: begin
               if (idx_q == LastIdx) begin
                  state_q <= StIdle;
                  idx_q   <= '0;
               end else begin
                  idx_q <= idx_q + IdxW'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign in_ready  = (state_q == StIdle) || (state_q == StLoad);
   assign out_valid = (state_q == StOut);
   assign out_last  = out_valid && (idx_q == LastIdx);
   assign x_out     = out_valid ? x_old : '0;
   assign iter_cnt  = iter_q;
   assign converged = conv_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_gsim_param_solver.sv
// Bench for gsim_param_solver: five parameterisations share clock, reset and the b stream;
// each run targets one instance and compares against a plain-arithmetic Gauss-Seidel model.
module tb_gsim_param_solver;

   typedef longint vec_t [64];

   typedef struct {
      int     sel;
      int     pat;     // 0 fixed pattern, 1 constant, 2 random
      longint bc;
      bit     gaps;
      bit     poke;
      int     e_iter;  // -1: model only
      int     e_conv;
      int     e_ovf;
      bit     chk_x0;
      longint e_x0;
   } tc_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b0;
   logic        in_en = 1'b0;
   logic [15:0] b_in  = '0;

   logic        rdy [5];
   logic        ov  [5];
   logic        ol  [5];
   logic        cv  [5];
   logic        of  [5];
   logic [31:0] xo0, xo1, xo2, xo3;
   logic [19:0] xo4;
   logic [6:0]  it0, it1, it2, it4;
   logic [1:0]  it3;

   gsim_param_solver u0 (
      .clk(clk), .reset(reset), .in_en(in_en), .b_in(b_in), .in_ready(rdy[0]),
      .out_valid(ov[0]), .out_last(ol[0]), .x_out(xo0), .iter_cnt(it0),
      .converged(cv[0]), .ovf(of[0]));
   gsim_param_solver #(.N(1)) u1 (
      .clk(clk), .reset(reset), .in_en(in_en), .b_in(b_in), .in_ready(rdy[1]),
      .out_valid(ov[1]), .out_last(ol[1]), .x_out(xo1), .iter_cnt(it1),
      .converged(cv[1]), .ovf(of[1]));
   gsim_param_solver #(.N(4)) u2 (
      .clk(clk), .reset(reset), .in_en(in_en), .b_in(b_in), .in_ready(rdy[2]),
      .out_valid(ov[2]), .out_last(ol[2]), .x_out(xo2), .iter_cnt(it2),
      .converged(cv[2]), .ovf(of[2]));
   gsim_param_solver #(.MAX_ITER(3), .CONV_EN(1'b0)) u3 (
      .clk(clk), .reset(reset), .in_en(in_en), .b_in(b_in), .in_ready(rdy[3]),
      .out_valid(ov[3]), .out_last(ol[3]), .x_out(xo3), .iter_cnt(it3),
      .converged(cv[3]), .ovf(of[3]));
   gsim_param_solver #(.XW(20)) u4 (
      .clk(clk), .reset(reset), .in_en(in_en), .b_in(b_in), .in_ready(rdy[4]),
      .out_valid(ov[4]), .out_last(ol[4]), .x_out(xo4), .iter_cnt(it4),
      .converged(cv[4]), .ovf(of[4]));

   int     p_n    [5] = '{16, 1, 4, 16, 16};
   int     p_xw   [5] = '{32, 32, 32, 32, 20};
   int     p_max  [5] = '{64, 64, 64, 3, 64};
   bit     p_conv [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
   longint p0_tab [16] = '{100, -250, 400, -75, 1200, -900, 30, 0,
                           500, -600, 777, -1, 2, 333, -1000, 64};

   int     sel = 0;
   logic   m_ready, m_valid, m_last, m_conv, m_ovf;
   longint m_x;
   int     m_iter;
   longint cap_x0;
   int     n_cmp = 0;
   int     n_bad = 0;

   always_comb begin
      m_ready = rdy[sel];
      m_valid = ov[sel];
      m_last  = ol[sel];
      m_conv  = cv[sel];
      m_ovf   = of[sel];
      m_x     = 0;
      m_iter  = 0;
      case (sel)
         0: begin m_x = longint'($signed(xo0)); m_iter = int'(it0); end
         1: begin m_x = longint'($signed(xo1)); m_iter = int'(it1); end
         2: begin m_x = longint'($signed(xo2)); m_iter = int'(it2); end
         3: begin m_x = longint'($signed(xo3)); m_iter = int'(it3); end
         default: begin m_x = longint'($signed(xo4)); m_iter = int'(it4); end
      endcase
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic longint coef(input int d);
      case (d)
         1: return 13;
         2: return -6;
         default: return 1;
      endcase
   endfunction

   // Straight Gauss-Seidel in 64-bit integers with floor division and XW saturation.
   function automatic void model(input int n, input int xw, input int maxit, input bit cen,
                                 input vec_t b, output vec_t x, output int iters,
                                 output bit conv, output bit ovfl);
      longint hi, lo, s, q, d, dmax;
      hi = (longint'(1) <<< (xw - 1)) - 1;
      lo = -hi - 1;
      for (int i = 0; i < 64; i++) x[i] = 0;
      iters = 0;
      conv  = 1'b0;
      ovfl  = 1'b0;
      for (int it = 1; it <= maxit; it++) begin
         dmax = 0;
         for (int i = 0; i < n; i++) begin
            s = b[i] * 65536;
            for (int k = 1; k <= 3; k++) begin
               if (i - k >= 0) s += coef(k) * x[i - k];
               if (i + k < n) s += coef(k) * x[i + k];
            end
            q = (s - (((s % 20) + 20) % 20)) / 20;
            if (q > hi) begin q = hi; ovfl = 1'b1; end
            else if (q < lo) begin q = lo; ovfl = 1'b1; end
            d = (q > x[i]) ? q - x[i] : x[i] - q;
            if (d > dmax) dmax = d;
            x[i] = q;
         end
         iters = it;
         if (cen && dmax == 0) begin
            conv = 1'b1;
            break;
         end
      end
   endfunction

   task automatic chk_reset(input string nm);
      chk({nm, ".ready"}, longint'(m_ready), 1);
      chk({nm, ".valid"}, longint'(m_valid), 0);
      chk({nm, ".last"}, longint'(m_last), 0);
      chk({nm, ".x"}, m_x, 0);
      chk({nm, ".iter"}, longint'(m_iter), 0);
      chk({nm, ".conv"}, longint'(m_conv), 0);
      chk({nm, ".ovf"}, longint'(m_ovf), 0);
   endtask

   task automatic do_reset(input string nm);
      @(negedge clk);
      reset = 1'b0;
      in_en = 1'b0;
      #1;
      chk_reset(nm);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic drive_b(input int n, input vec_t b, input bit gaps);
      for (int i = 0; i < n; i++) begin
         in_en = 1'b0;
         if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
         in_en = 1'b1;
         b_in  = b[i][15:0];
         @(negedge clk);
      end
      in_en = 1'b0;
   endtask

   task automatic collect(input string nm, input int n, input vec_t ex, input int e_it,
                          input bit e_cv, input bit e_of, input bit poke);
      int lat = 1;
      int bound = e_it * n + 20;
      while (!m_valid && lat < bound) begin
         if (poke) begin
            chk({nm, ".ready_solve"}, longint'(m_ready), 0);
            in_en = 1'($urandom_range(0, 1));
            b_in  = 16'($urandom);
         end
         @(negedge clk);
         lat++;
      end
      if (!m_valid) begin
         chk({nm, ".timeout"}, 0, 1);
         in_en = 1'b0;
         return;
      end
      chk({nm, ".latency"}, lat, e_it * n + 1);
      cap_x0 = m_x;
      for (int i = 0; i < n; i++) begin
         chk({nm, ".valid"}, longint'(m_valid), 1);
         chk({nm, ".x"}, m_x, ex[i]);
         chk({nm, ".last"}, longint'(m_last), (i == n - 1) ? 1 : 0);
         if (poke) begin
            chk({nm, ".ready_out"}, longint'(m_ready), 0);
            in_en = 1'($urandom_range(0, 1));
            b_in  = 16'($urandom);
         end
         @(negedge clk);
      end
      in_en = 1'b0;
      chk({nm, ".valid_after"}, longint'(m_valid), 0);
      chk({nm, ".ready_after"}, longint'(m_ready), 1);
      chk({nm, ".iter"}, longint'(m_iter), longint'(e_it));
      chk({nm, ".conv"}, longint'(m_conv), longint'(e_cv));
      chk({nm, ".ovf"}, longint'(m_ovf), longint'(e_of));
   endtask

   function automatic void build_b(input tc_t t, output vec_t b);
      for (int i = 0; i < 64; i++) b[i] = 0;
      for (int i = 0; i < p_n[t.sel]; i++) begin
         case (t.pat)
            0: b[i] = p0_tab[i % 16];
            1: b[i] = t.bc;
            default: b[i] = longint'($urandom_range(0, 4000)) - 2000;
         endcase
      end
   endfunction

   task automatic run_case(input tc_t t, input string nm);
      vec_t b, ex;
      int   it;
      bit   cvm, ofm;
      sel = t.sel;
      build_b(t, b);
      model(p_n[t.sel], p_xw[t.sel], p_max[t.sel], p_conv[t.sel], b, ex, it, cvm, ofm);
      do_reset({nm, ".rst"});
      drive_b(p_n[t.sel], b, t.gaps);
      collect(nm, p_n[t.sel], ex, it, cvm, ofm, t.poke);
      if (t.e_iter >= 0) chk({nm, ".tbl_iter"}, longint'(m_iter), longint'(t.e_iter));
      if (t.e_conv >= 0) chk({nm, ".tbl_conv"}, longint'(m_conv), longint'(t.e_conv));
      if (t.e_ovf >= 0) chk({nm, ".tbl_ovf"}, longint'(m_ovf), longint'(t.e_ovf));
      if (t.chk_x0) chk({nm, ".tbl_x0"}, cap_x0, t.e_x0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tc_t  tbl [7];
      vec_t b, ex;
      int   it;
      bit   cvm, ofm;

      tbl[0] = '{sel: 0, pat: 0, bc: 0, gaps: 0, poke: 0, e_iter: -1, e_conv: -1,
                 e_ovf: 0, chk_x0: 0, e_x0: 0};
      tbl[1] = '{sel: 1, pat: 1, bc: 20, gaps: 0, poke: 0, e_iter: 2, e_conv: 1,
                 e_ovf: 0, chk_x0: 1, e_x0: 64'h10000};
      tbl[2] = '{sel: 1, pat: 1, bc: -20, gaps: 0, poke: 0, e_iter: 2, e_conv: 1,
                 e_ovf: 0, chk_x0: 1, e_x0: -65536};
      tbl[3] = '{sel: 2, pat: 1, bc: 0, gaps: 0, poke: 0, e_iter: 1, e_conv: 1,
                 e_ovf: 0, chk_x0: 1, e_x0: 0};
      tbl[4] = '{sel: 3, pat: 0, bc: 0, gaps: 0, poke: 0, e_iter: 3, e_conv: 0,
                 e_ovf: 0, chk_x0: 0, e_x0: 0};
      tbl[5] = '{sel: 0, pat: 0, bc: 0, gaps: 1, poke: 1, e_iter: -1, e_conv: -1,
                 e_ovf: 0, chk_x0: 0, e_x0: 0};
      tbl[6] = '{sel: 4, pat: 1, bc: 64'h7FFF, gaps: 0, poke: 0, e_iter: -1, e_conv: -1,
                 e_ovf: 1, chk_x0: 1, e_x0: 64'h7FFFF};

      reset = 1'b0;
      #1;
      chk_reset("por");
      for (int i = 0; i < 7; i++) run_case(tbl[i], $sformatf("tbl%0d", i));

      // Random b vectors with gaps and ignored in_en pulses on the 16- and 4-unknown solvers.
      for (int i = 0; i < 4; i++) begin
         tc_t t;
         t = '{sel: (i % 2 == 0) ? 0 : 2, pat: 2, bc: 0, gaps: 1, poke: 1, e_iter: -1,
               e_conv: -1, e_ovf: -1, chk_x0: 0, e_x0: 0};
         run_case(t, $sformatf("rnd%0d", i));
      end

      // Reset during sweep 2, element 7, then reload the fixed pattern.
      sel = 0;
      build_b(tbl[0], b);
      model(16, 32, 64, 1'b1, b, ex, it, cvm, ofm);
      do_reset("mid.pre");
      drive_b(16, b, 1'b0);
      repeat (23) @(negedge clk);
      chk("mid.busy_ready", longint'(m_ready), 0);
      chk("mid.busy_valid", longint'(m_valid), 0);
      reset = 1'b0;
      #1;
      chk_reset("mid.rst");
      @(negedge clk);
      chk("mid.no_output", longint'(m_valid), 0);
      reset = 1'b1;
      @(negedge clk);
      drive_b(16, b, 1'b0);
      collect("mid.reload", 16, ex, it, cvm, ofm, 1'b0);
      chk("mid.reload_ovf", longint'(m_ovf), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
